// File: rtl/rx_buffer_if.sv
// Upstream/downstream handshake bundle for rx_buffer.
// Item width defaults from `PAYLOAD_SIZE and `ADDR_BITS when not predefined.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

interface rx_buffer_if #(
    parameter int unsigned IW = `PAYLOAD_SIZE + `ADDR_BITS
);
    logic          ena;
    logic [IW-1:0] item_in;
    logic          busy;
    logic          read;
    logic          empty;
    logic [IW-1:0] item_out;

    modport master (output ena, item_in, read, input busy, empty, item_out);
    modport slave  (input ena, item_in, read, output busy, empty, item_out);
endinterface

// File: rtl/rx_buffer.sv
// First-word-fall-through circular receive buffer with async active-low reset.
// Optional occupancy/peak statistics ports enabled by macro RX_BUFFER_STATS_EN.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module rx_buffer #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rx_buffer_if.slave    bus
`ifdef RX_BUFFER_STATS_EN
    ,
    output logic [CW-1:0] occupancy,
    output logic [CW-1:0] peak
`endif
);
    localparam int unsigned IW = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          full;
    logic          none;
    logic          wr_en;
    logic          rd_en;

    // Status decoded purely from the count register, never from inputs.
    assign full  = (count == CW'(DEPTH));
    assign none  = (count == CW'(0));
    assign wr_en = bus.ena && !full;
    assign rd_en = bus.read && !none;

    assign bus.busy     = full;
    assign bus.empty    = none;
    assign bus.item_out = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.item_in;
    end

`ifdef RX_BUFFER_STATS_EN
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (count_nxt > peak_q) begin
            peak_q <= count_nxt;
        end
    end

    assign occupancy = count;
    assign peak      = peak_q;
`endif
endmodule

// File: tb/tb_rx_buffer.sv
// Self-checking bench for rx_buffer: directed table, corner sequences and a
// randomized run against a queue-based reference model.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module tb_rx_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_buffer_if #(.IW(IW)) bus ();

`ifdef RX_BUFFER_STATS_EN
    logic [CW-1:0] occupancy;
    logic [CW-1:0] peak;
    rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .occupancy(occupancy), .peak(peak)
    );
`else
    rx_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: an ordered list of buffered items plus the high-water mark.
    logic [IW-1:0] q[$];
    int            peak_m = 0;

    typedef struct {
        logic          ena;
        logic          read;
        logic [IW-1:0] data;
        int            exp_cnt;
        logic [IW-1:0] exp_head;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, "_busy"},  32'(bus.busy),  32'(q.size() == DEPTH));
        if (q.size() > 0) chk({tag, "_head"}, 32'(bus.item_out), 32'(q[0]));
`ifdef RX_BUFFER_STATS_EN
        chk({tag, "_occ"},  32'(occupancy), 32'(q.size()));
        chk({tag, "_peak"}, 32'(peak),      32'(peak_m));
`endif
    endtask

    // One clock cycle: drive, let the edge pass, update model, compare.
    task automatic cyc(input logic e, input logic r, input logic [IW-1:0] d, input string tag);
        bit acc_w, acc_r;
        bus.ena = e; bus.read = r; bus.item_in = d;
        acc_w = e && (q.size() < DEPTH);
        acc_r = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (acc_r) void'(q.pop_front());
        if (acc_w) q.push_back(d);
        if (q.size() > peak_m) peak_m = q.size();
        bus.ena = 1'b0; bus.read = 1'b0;
        check_model(tag);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        peak_m = 0;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_busy",  32'(bus.busy),  32'd0);
`ifdef RX_BUFFER_STATS_EN
        chk("rst_peak", 32'(peak), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ena = 1'b0; bus.read = 1'b0; bus.item_in = '0;
        rst_n = 1'b0;
        #1;
        chk("por_empty", 32'(bus.empty), 32'd1);
        chk("por_busy",  32'(bus.busy),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill, drop on full, full+ena+read, drain, read-while-empty, empty+ena+read.
        tbl[0]  = '{1'b1, 1'b0, IW'('h0A), 1, IW'('h0A)};
        tbl[1]  = '{1'b1, 1'b0, IW'('h0B), 2, IW'('h0A)};
        tbl[2]  = '{1'b1, 1'b0, IW'('h0C), 3, IW'('h0A)};
        tbl[3]  = '{1'b1, 1'b0, IW'('h0D), 4, IW'('h0A)};
        tbl[4]  = '{1'b1, 1'b0, IW'('h0E), 4, IW'('h0A)};
        tbl[5]  = '{1'b1, 1'b1, IW'('h99), 3, IW'('h0B)};
        tbl[6]  = '{1'b0, 1'b1, IW'('h00), 2, IW'('h0C)};
        tbl[7]  = '{1'b1, 1'b1, IW'('h0F), 2, IW'('h0D)};
        tbl[8]  = '{1'b0, 1'b1, IW'('h00), 1, IW'('h0F)};
        tbl[9]  = '{1'b0, 1'b1, IW'('h00), 0, IW'('h00)};
        tbl[10] = '{1'b0, 1'b1, IW'('h00), 0, IW'('h00)};
        tbl[11] = '{1'b0, 1'b1, IW'('h00), 0, IW'('h00)};
        tbl[12] = '{1'b1, 1'b1, IW'('h77), 1, IW'('h77)};
        tbl[13] = '{1'b0, 1'b1, IW'('h00), 0, IW'('h00)};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].ena, tbl[i].read, tbl[i].data, "tbl_model");
            chk("tbl_empty", 32'(bus.empty), 32'(tbl[i].exp_cnt == 0));
            chk("tbl_busy",  32'(bus.busy),  32'(tbl[i].exp_cnt == DEPTH));
            if (tbl[i].exp_cnt > 0) chk("tbl_head", 32'(bus.item_out), 32'(tbl[i].exp_head));
`ifdef RX_BUFFER_STATS_EN
            chk("tbl_occ", 32'(occupancy), 32'(tbl[i].exp_cnt));
`endif
        end

        // Reset mid-burst with three items buffered, then 0x5A becomes head.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, IW'(8'h20 + i), "burst");
        async_reset();
        cyc(1'b1, 1'b0, IW'('h5A), "post_rst");
        chk("post_rst_head", 32'(bus.item_out), 32'h5A);
        cyc(1'b0, 1'b1, '0, "post_rst_pop");

        // Interleaved write/pop pairs walk the pointers around twice.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, IW'(i), "wrap_w");
            chk("wrap_order", 32'(bus.item_out), 32'(i));
            cyc(1'b0, 1'b1, '0, "wrap_r");
        end

`ifdef RX_BUFFER_STATS_EN
        async_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, IW'(i), "st_fill");
        chk("st_peak3", 32'(peak), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            cyc(1'b0, 1'b1, '0, "st_drain");
            chk("st_occ", 32'(occupancy), 32'(i));
            chk("st_peak_hold", 32'(peak), 32'd3);
        end
        async_reset();
`endif

        // Randomized traffic: write-heavy phase then read-heavy phase.
        for (int i = 0; i < 2000; i++) begin
            logic e, r;
            e = ($urandom_range(0, 99) < ((i < 1000) ? 70 : 30));
            r = ($urandom_range(0, 99) < ((i < 1000) ? 35 : 70));
            cyc(e, r, IW'($urandom), "rand");
            if (i == 1500) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
